// File: rtl/al422_bam_pkg.sv
// AL422 BAM generator shared types: FSM state enums, default parameters
// and a clog2 helper. Feature macro: AL422_BAM_DEADTIME_EN.
package al422_bam_pkg;

  localparam int DEF_COLS       = 64;
  localparam int DEF_ROW_BITS   = 5;
  localparam int DEF_PLANES     = 8;
  localparam int DEF_BASE_TICKS = 4;
  localparam int DEF_DEAD_TICKS = 8;

  typedef enum logic [1:0] {
    FIFO_RST,
    SHIFT,
    WAIT,
    LATCH
  } state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_BLANK,
    T_RUN
  } tmr_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bam_plane_timer.sv
// Display-period timer: loads BASE_TICKS<<p on start, drives active-low oe
// and reports done. With AL422_BAM_DEADTIME_EN a row change (blank=1) first
// holds oe high for DEAD_TICKS cycles (BLANK phase).
// Ports: clk, rst_n, start, load, [blank], done, oe.
module bam_plane_timer
  import al422_bam_pkg::*;
#(
  parameter int TW = 4
`ifdef AL422_BAM_DEADTIME_EN
  ,
  parameter int DEAD_TICKS = DEF_DEAD_TICKS
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [TW-1:0] load,
`ifdef AL422_BAM_DEADTIME_EN
  input  logic          blank,
`endif
  output logic          done,
  output logic          oe
);

  tmr_e          phase;
  tmr_e          phase_n;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_n;
  logic          oe_n;

`ifdef AL422_BAM_DEADTIME_EN
  localparam int DW = clog2(DEAD_TICKS) + 1;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_n;
  logic [TW-1:0] held;
  logic [TW-1:0] held_n;
`endif

  // done = idle, or the current cycle is the last display cycle
  assign done = (phase == T_IDLE) ||
                ((phase == T_RUN) && (cnt == TW'(1)));

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    oe_n    = oe;
`ifdef AL422_BAM_DEADTIME_EN
    dcnt_n  = dcnt;
    held_n  = held;
`endif
    if (start) begin
`ifdef AL422_BAM_DEADTIME_EN
      if (blank && (DEAD_TICKS > 0)) begin
        phase_n = T_BLANK;
        dcnt_n  = DW'(DEAD_TICKS);
        held_n  = load;
      end else
`endif
      begin
        phase_n = T_RUN;
        cnt_n   = load;
        oe_n    = 1'b0;
      end
    end else begin
      unique case (phase)
`ifdef AL422_BAM_DEADTIME_EN
        T_BLANK: begin
          if (dcnt == DW'(1)) begin
            phase_n = T_RUN;
            cnt_n   = held;
            oe_n    = 1'b0;
          end else begin
            dcnt_n = dcnt - 1'b1;
          end
        end
`endif
        T_RUN: begin
          if (cnt == TW'(1)) begin
            phase_n = T_IDLE;
            oe_n    = 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= T_IDLE;
      cnt   <= '0;
      oe    <= 1'b1;
`ifdef AL422_BAM_DEADTIME_EN
      dcnt  <= '0;
      held  <= '0;
`endif
    end else begin
      phase <= phase_n;
      cnt   <= cnt_n;
      oe    <= oe_n;
`ifdef AL422_BAM_DEADTIME_EN
      dcnt  <= dcnt_n;
      held  <= held_n;
`endif
    end
  end

endmodule

// File: rtl/al422_bam_gen.sv
// AL422 FIFO to HUB75 BAM scanner: FIFO reset, 2-cycle pixel shift, latch,
// row/plane sequencing; display timing lives in bam_plane_timer.
// Ports: in_clk, in_nrst, in_data -> al422_nrst_out, al422_re_out,
// led_clk_out, led_lat_out, led_oe_out, led_row, rgb1, rgb2.
// Optional dead time on row change: AL422_BAM_DEADTIME_EN.
module al422_bam_gen
  import al422_bam_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROW_BITS   = DEF_ROW_BITS,
  parameter int PLANES     = DEF_PLANES,
  parameter int BASE_TICKS = DEF_BASE_TICKS,
  parameter int DEAD_TICKS = DEF_DEAD_TICKS
) (
  input  logic                in_clk,
  input  logic                in_nrst,
  input  logic [7:0]          in_data,
  output logic                al422_nrst_out,
  output logic                al422_re_out,
  output logic                led_clk_out,
  output logic                led_lat_out,
  output logic                led_oe_out,
  output logic [ROW_BITS-1:0] led_row,
  output logic [2:0]          rgb1,
  output logic [2:0]          rgb2
);

  localparam int CW = (clog2(COLS) < 1) ? 1 : clog2(COLS);
  localparam int PW = (clog2(PLANES) < 1) ? 1 : clog2(PLANES);
  localparam int TW = clog2(BASE_TICKS << (PLANES - 1)) + 1;

  state_e              state;
  state_e              state_n;
  logic                ph;
  logic                ph_n;
  logic                armed;
  logic [CW-1:0]       col;
  logic [PW-1:0]       plane;
  logic [ROW_BITS-1:0] row;
  logic                shift_end;
  logic                last_plane;
  logic                last_row;
  logic                tmr_start;
  logic                tmr_done;
  logic [TW-1:0]       tmr_load;
  logic [1:0]          unused_data;

  assign unused_data = in_data[7:6];
  assign last_plane  = (plane == PW'(PLANES - 1));
  assign last_row    = (row == '1);
  assign tmr_start   = (state == LATCH);
  assign tmr_load    = TW'(BASE_TICKS) << plane;

  // ph: 0 = cycle A (read, clk low), 1 = cycle B (clk high)
  always_comb begin
    state_n   = state;
    ph_n      = 1'b0;
    shift_end = (state == SHIFT) && ph && (col == CW'(COLS - 1));
    unique case (state)
      FIFO_RST: begin
        if (armed) state_n = SHIFT;
      end
      SHIFT: begin
        ph_n = ~ph;
        if (shift_end) state_n = tmr_done ? LATCH : WAIT;
      end
      WAIT: begin
        if (tmr_done) state_n = LATCH;
      end
      LATCH: begin
        state_n = (last_plane && last_row) ? FIFO_RST : SHIFT;
      end
      default: state_n = FIFO_RST;
    endcase
  end

  // armed stretches the post-reset FIFO_RST by one cycle
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state          <= FIFO_RST;
      armed          <= 1'b0;
      ph             <= 1'b0;
      col            <= '0;
      plane          <= '0;
      row            <= '0;
      al422_nrst_out <= 1'b0;
      al422_re_out   <= 1'b1;
      led_clk_out    <= 1'b0;
      led_lat_out    <= 1'b0;
      led_row        <= '0;
      rgb1           <= '0;
      rgb2           <= '0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
      ph    <= ph_n;
      if ((state == SHIFT) && ph) begin
        col <= (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
      end
      if (state == LATCH) begin
        plane <= last_plane ? '0 : plane + 1'b1;
        if (last_plane) row <= row + 1'b1;
      end
      if ((state == SHIFT) && !ph) begin
        rgb1 <= in_data[2:0];
        rgb2 <= in_data[5:3];
      end
      if ((state_n == LATCH) && (plane == '0)) begin
        led_row <= row;
      end
      al422_nrst_out <= (state_n != FIFO_RST);
      al422_re_out   <= !((state_n == SHIFT) && !ph_n);
      led_clk_out    <= (state_n == SHIFT) && ph_n;
      led_lat_out    <= (state_n == LATCH);
    end
  end

`ifdef AL422_BAM_DEADTIME_EN
  logic row_chg;

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      row_chg <= 1'b0;
    end else if (state_n == LATCH) begin
      row_chg <= (plane == '0) && (row != led_row);
    end
  end

  bam_plane_timer #(
    .TW         (TW),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_timer (
    .clk   (in_clk),
    .rst_n (in_nrst),
    .start (tmr_start),
    .load  (tmr_load),
    .blank (row_chg),
    .done  (tmr_done),
    .oe    (led_oe_out)
  );
`else
  localparam int unused_dead = DEAD_TICKS;

  bam_plane_timer #(
    .TW (TW)
  ) u_timer (
    .clk   (in_clk),
    .rst_n (in_nrst),
    .start (tmr_start),
    .load  (tmr_load),
    .done  (tmr_done),
    .oe    (led_oe_out)
  );
`endif

endmodule

// File: tb/tb_al422_bam_gen.sv
// Bench for al422_bam_gen: timeline reference model of the scan sequence,
// two DUTs (BASE_TICKS 2 and 8), random FIFO data and random resets.
module tb_al422_bam_gen;

  localparam int C    = 4;
  localparam int P    = 2;
  localparam int NR   = 2;
  localparam int DT   = 3;
  localparam int NC   = 256;
`ifdef AL422_BAM_DEADTIME_EN
  localparam int DEAD = DT;
`else
  localparam int DEAD = 0;
`endif
  localparam logic [11:0] RST_VEC = 12'h480;

  logic in_clk = 1'b0;
  logic in_nrst;
  logic [7:0] din0;
  logic [7:0] din1;

  logic n0, re0, ck0, lt0, oe0;
  logic n1, re1, ck1, lt1, oe1;
  logic [0:0] row0, row1;
  logic [2:0] ra0, rb0, ra1, rb1;

  logic [7:0]  mem [16];
  logic [11:0] ev [NC];
  int lat_t [64];
  int nlat;
  int nvec;
  int nbad;
  int sel;
  int rp0;
  int rp1;
  int k;

  always #5 in_clk = ~in_clk;

  al422_bam_gen #(
    .COLS(C), .ROW_BITS(1), .PLANES(P), .BASE_TICKS(2), .DEAD_TICKS(DT)
  ) dut0 (
    .in_clk(in_clk), .in_nrst(in_nrst), .in_data(din0),
    .al422_nrst_out(n0), .al422_re_out(re0),
    .led_clk_out(ck0), .led_lat_out(lt0), .led_oe_out(oe0),
    .led_row(row0), .rgb1(ra0), .rgb2(rb0)
  );

  al422_bam_gen #(
    .COLS(C), .ROW_BITS(1), .PLANES(P), .BASE_TICKS(8), .DEAD_TICKS(DT)
  ) dut1 (
    .in_clk(in_clk), .in_nrst(in_nrst), .in_data(din1),
    .al422_nrst_out(n1), .al422_re_out(re1),
    .led_clk_out(ck1), .led_lat_out(lt1), .led_oe_out(oe1),
    .led_row(row1), .rgb1(ra1), .rgb2(rb1)
  );

  // AL422 read side: pointer clears on nrst low, advances per re-low cycle
  initial begin
    logic s_n0, s_r0, s_n1, s_r1;
    rp0 = 0;
    rp1 = 0;
    din0 = 8'h00;
    din1 = 8'h00;
    forever begin
      @(negedge in_clk);
      s_n0 = n0; s_r0 = re0;
      s_n1 = n1; s_r1 = re1;
      @(posedge in_clk);
      #2;
      if (!s_n0) rp0 = 0; else if (!s_r0) rp0++;
      if (!s_n1) rp1 = 0; else if (!s_r1) rp1++;
      din0 = mem[rp0 % 16];
      din1 = mem[rp1 % 16];
    end
  end

  function automatic logic [11:0] vec(input int s);
    if (s == 0) return {n0, re0, ck0, lt0, oe0, row0, ra0, rb0};
    return {n1, re1, ck1, lt1, oe1, row1, ra1, rb1};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nbad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [11:0] got,
                      input logic [11:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Timeline model: t=0 is the cycle after the first edge past release.
  task automatic build(input int base);
    logic en [NC];
    logic er [NC];
    logic ec [NC];
    logic el [NC];
    logic eo [NC];
    int rowset [NC];
    int rgbset [NC];
    logic [7:0] b;
    logic rowc;
    logic [5:0] rgbc;
    int ts, pl, rw, cur, pend, rd, lat, d, a;
    for (int t = 0; t < NC; t++) begin
      en[t] = 1'b1; er[t] = 1'b1; ec[t] = 1'b0;
      el[t] = 1'b0; eo[t] = 1'b1;
      rowset[t] = -1; rgbset[t] = -1;
    end
    en[0] = 1'b0;
    rowset[0] = 0;
    rgbset[0] = 0;
    ts = 1; pl = 0; rw = 0; cur = 0; pend = -1; rd = 0; nlat = 0;
    while (ts < NC && nlat < 64) begin
      for (int j = 0; j < C; j++) begin
        a = ts + 2 * j;
        b = mem[rd];
        if (a < NC) er[a] = 1'b0;
        if (a + 1 < NC) begin
          ec[a + 1] = 1'b1;
          rgbset[a + 1] = int'({b[2:0], b[5:3]});
        end
        rd++;
      end
      lat = ts + 2 * C;
      if (pend + 1 > lat) lat = pend + 1;
      if (lat < NC) el[lat] = 1'b1;
      lat_t[nlat] = lat;
      nlat++;
      d = 0;
      if (pl == 0) begin
        if (rw != cur) d = DEAD;
        cur = rw;
        if (lat < NC) rowset[lat] = rw;
      end
      for (int i = 0; i < (base << pl); i++)
        if (lat + 1 + d + i < NC) eo[lat + 1 + d + i] = 1'b0;
      pend = lat + d + (base << pl);
      ts = lat + 1;
      pl++;
      if (pl == P) begin
        pl = 0;
        rw++;
        if (rw == NR) begin
          rw = 0;
          rd = 0;
          if (lat + 1 < NC) en[lat + 1] = 1'b0;
          ts = lat + 2;
        end
      end
    end
    rowc = 1'b0;
    rgbc = 6'd0;
    for (int t = 0; t < NC; t++) begin
      if (rowset[t] >= 0) rowc = rowset[t][0];
      if (rgbset[t] >= 0) rgbc = rgbset[t][5:0];
      ev[t] = {en[t], er[t], ec[t], el[t], eo[t], rowc, rgbc};
    end
  endtask

  function automatic int lows(input int a, input int b);
    int n = 0;
    for (int t = a + 1; t < b; t++) if (!ev[t][7]) n++;
    return n;
  endfunction

  function automatic int re_lows(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) if (!ev[t][10]) n++;
    return n;
  endfunction

  function automatic int first_low(input int a);
    for (int t = a + 1; t < NC; t++) if (!ev[t][7]) return t;
    return NC;
  endfunction

  task automatic pin(input int base);
    if (base == 2) begin
      chk("pin_lat0", lat_t[0], 9);
      chk("pin_lat_gap", lat_t[1] - lat_t[0], 9);
      chk("pin_p0_oe", lows(lat_t[0], lat_t[1]), 2);
      chk("pin_p1_oe", lows(lat_t[1], lat_t[2]), 4);
      chk("pin_frame_re", re_lows(0, lat_t[3]), 16);
      chk("pin_fifo_rst", int'(ev[lat_t[3] + 1][11]), 0);
      chk("pin_rows", int'({ev[lat_t[0]][6], ev[lat_t[2]][6],
                            ev[lat_t[4]][6]}), 2);
      chk("pin_dead_row", first_low(lat_t[2]) - lat_t[2], DEAD + 1);
      chk("pin_dead_same", first_low(lat_t[1]) - lat_t[1], 1);
    end else begin
      chk("pin8_gap", lat_t[2] - lat_t[1], 17);
      chk("pin8_p1_oe", lows(lat_t[1], lat_t[2]), 16);
    end
  endtask

  task automatic run(input int a, input int b);
    for (int t = a; t < b; t++) begin
      @(posedge in_clk);
      #1;
      chkv($sformatf("cyc%0d_dut%0d", t, sel), vec(sel), ev[t]);
    end
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    sel = 0;
    in_nrst = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h2A;
    repeat (3) @(negedge in_clk);
    chkv("rst_hold0", vec(0), RST_VEC);
    chkv("rst_hold1", vec(1), RST_VEC);

    build(2);
    pin(2);
    @(negedge in_clk);
    in_nrst = 1'b1;
    run(0, 3);
    chkv("rgb_first", {6'd0, ra0, rb0}, 12'h015);
    run(3, 40);
    chk("fifo_addr_wrap", rp0, 0);
    run(40, 120);

    @(negedge in_clk);
    in_nrst = 1'b0;
    repeat (2) @(negedge in_clk);
    @(negedge in_clk);
    in_nrst = 1'b1;
    run(0, 6);
    #2 in_nrst = 1'b0;
    #1 chkv("mid_rst", vec(0), RST_VEC);
    repeat (3) begin
      @(posedge in_clk);
      #1 chkv("rst_held", vec(0), RST_VEC);
    end
    @(negedge in_clk);
    in_nrst = 1'b1;
    run(0, 60);

    sel = 1;
    @(negedge in_clk);
    in_nrst = 1'b0;
    repeat (2) @(negedge in_clk);
    build(8);
    pin(8);
    @(negedge in_clk);
    in_nrst = 1'b1;
    run(0, 150);
    @(negedge in_clk);
    in_nrst = 1'b0;
    repeat (2) @(negedge in_clk);

    for (int it = 0; it < 4; it++) begin
      sel = int'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      build(sel == 1 ? 8 : 2);
      @(negedge in_clk);
      in_nrst = 1'b1;
      k = int'($urandom_range(4, 130));
      run(0, k);
      #2 in_nrst = 1'b0;
      #1 chkv($sformatf("rnd_rst%0d", it), vec(sel), RST_VEC);
      repeat (2) @(negedge in_clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/al422_bam_gen.md
AL422_BAM_GEN -- requirements
Module: al422_bam_gen

Interface
REQ-001 Parameter COLS, default 64: pixels per panel row shifted per bit plane, minimum 2.
REQ-002 Parameter ROW_BITS, default 5: row-address width, giving 2^ROW_BITS scan rows.
REQ-003 Parameter PLANES, default 8: BAM bit planes per row, range 1..12.
REQ-004 Parameter BASE_TICKS, default 4: in_clk cycles of display for plane 0, minimum 1.
REQ-005 Parameter DEAD_TICKS, default 8: extra blanking cycles on row change, used only under REQ-027.
REQ-006 Port in_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-007 Port in_nrst, input, 1: reset, asynchronous, active-low.
REQ-008 Port in_data, input, 8: AL422 read data; [2:0] upper-half RGB, [5:3] lower-half RGB, [7:6] ignored.
REQ-009 Port al422_nrst_out, output, 1: AL422 read-pointer reset, active-low.
REQ-010 Port al422_re_out, output, 1: AL422 read enable, active-low.
REQ-011 Ports led_clk_out, led_lat_out, led_oe_out: outputs, 1 each, HUB75 shift clock, latch (active-high) and output enable (active-low).
REQ-012 Ports led_row (output, ROW_BITS), rgb1 (output, 3) and rgb2 (output, 3): row address, upper-half data and lower-half data.

Function
REQ-013 FIFO order: row-major, then plane 0..PLANES-1, then COLS bytes; one frame is COLS*PLANES*2^ROW_BITS reads.
REQ-014 Pixel transfer takes 2 cycles:
- Cycle A: al422_re_out=0, led_clk_out=0; rgb1<=in_data[2:0] and rgb2<=in_data[5:3] at the edge ending cycle A.
- Cycle B: al422_re_out=1, led_clk_out=1.
REQ-015 Each plane shift takes exactly 2*COLS cycles, and al422_re_out is never low outside cycle A.
REQ-016 States: FIFO_RST -> SHIFT -> WAIT -> LATCH -> SHIFT/FIFO_RST, with BLANK added under REQ-027.
REQ-017 LATCH is one cycle with led_lat_out=1 and led_oe_out=1; led_row takes the new row in the LATCH that loads plane 0 of that row.
REQ-018 In the cycle after LATCH, led_oe_out goes 0 for exactly BASE_TICKS<<p cycles (p = plane latched), and the shift of the next plane starts in that same cycle.
REQ-019 WAIT holds until both the shift and the display count are complete; LATCH follows on the next cycle, and led_oe_out stays 1 between display end and LATCH.
REQ-020 After the LATCH of the last plane of the last row, the next cycle is FIFO_RST (al422_nrst_out=0 for exactly 1 cycle), the shift of row 0 plane 0 follows, and the display count runs from the LATCH regardless.
REQ-021 Row counter and plane counter wrap to 0 with no gap other than REQ-020; the display counter width is clog2(BASE_TICKS<<(PLANES-1))+1, with no overflow.
REQ-022 At power-up there is no display before the first LATCH: led_oe_out stays 1 through FIFO_RST and the first shift.

Reset
REQ-023 in_nrst low forces immediately, independent of in_clk: al422_nrst_out=0, al422_re_out=1, led_clk_out=0, led_lat_out=0, led_oe_out=1, led_row=0, rgb1=0, rgb2=0, all counters 0, state FIFO_RST.
REQ-024 On the first edge after deassertion, al422_nrst_out stays 0 for 1 cycle, then the first shift starts.
REQ-025 Reset mid-shift or mid-display abandons the frame; no partial LATCH occurs, and the restart follows REQ-024.
REQ-026 All outputs are registered, so no output glitches.

Configuration
REQ-027 Macro AL422_BAM_DEADTIME_EN, when defined:
- Every LATCH that changes led_row is followed by state BLANK, holding led_oe_out=1 for DEAD_TICKS cycles before the display count starts.
- The display length is unchanged, and the shift still starts the cycle after LATCH.
REQ-028 When AL422_BAM_DEADTIME_EN is undefined, there is no BLANK state, DEAD_TICKS is unused, and display starts the cycle after LATCH.

Structure
REQ-029 Package al422_bam_pkg holds the state enumeration, the default parameter constants and a clog2 function.
REQ-030 Sub-module bam_plane_timer (load value BASE_TICKS<<p, start, done) owns the display counter and led_oe_out timing; the shift/FIFO state machine stays in al422_bam_gen.

Verification (COLS=4, ROW_BITS=1, PLANES=2, BASE_TICKS=2 unless stated)
REQ-031 Reset: hold in_nrst=0 -> all outputs at REQ-023 values; release -> al422_nrst_out=0 for 1 cycle, first al422_re_out low on the following cycle.
REQ-032 Data path: FIFO byte 0 = 0x2A -> rgb1=3'b010 and rgb2=3'b101 at the first led_clk_out rise; 4 led_clk_out pulses, then one led_lat_out pulse after the shift completes.
REQ-033 Display timing:
- Plane 0 gives led_oe_out low for 2 cycles and plane 1 for 4 cycles, with LATCH-to-LATCH spacing of 9 cycles (shift-bound).
- With BASE_TICKS=8, plane 1 gives 16 cycles low and a LATCH 17 cycles after the previous one.
REQ-034 Frame wrap: 16 al422_re_out low cycles per frame, then al422_nrst_out low for exactly 1 cycle; led_row sequence 0,1,0 across frames; a model FIFO address returns to 0.
REQ-035 Mid-operation reset: in_nrst low during the 3rd pixel of a shift -> outputs reset within the same cycle, no led_lat_out pulse, and the restart matches REQ-031.
REQ-036 Dead time: with AL422_BAM_DEADTIME_EN and DEAD_TICKS=3 -> LATCH-to-led_oe_out fall is 4 cycles on a row change and 1 cycle otherwise; without the macro it is 1 cycle always.
